// File: rtl/tia_pkg.sv
// Shared TIA constants: horizontal LFSR configuration, its decode states and the object-counter end state.
package tia_pkg;

    localparam int unsigned TIA_HLFSR_WIDTH = 6;
    localparam logic [TIA_HLFSR_WIDTH-1:0] TIA_HLFSR_TAPS = 6'b110000;

    // Decode points expressed as advance counts from state zero.
    localparam int unsigned TIA_HCNT_SHS  = 4;
    localparam int unsigned TIA_HCNT_RHS  = 8;
    localparam int unsigned TIA_HCNT_RCB  = 12;
    localparam int unsigned TIA_HCNT_RHB  = 16;
    localparam int unsigned TIA_HCNT_LRHB = 18;
    localparam int unsigned TIA_HCNT_CNT  = 36;
    localparam int unsigned TIA_HCNT_SHB  = 56;
    localparam int unsigned TIA_OBJ_LAST  = 39;

    typedef logic [TIA_HLFSR_WIDTH-1:0] tia_hstate_t;

    // State reached after 'steps' advances from zero; keeps every decode consistent with the taps.
    function automatic tia_hstate_t tia_hlfsr_walk(input int unsigned steps);
        tia_hstate_t s;
        s = '0;
        for (int unsigned i = 0; i < steps; i++) begin
            s = {s[TIA_HLFSR_WIDTH-2:0], ~^(s & TIA_HLFSR_TAPS)};
        end
        return s;
    endfunction

    localparam tia_hstate_t TIA_HLFSR_END  = tia_hlfsr_walk(TIA_HCNT_SHB);
    localparam tia_hstate_t TIA_HDEC_SHS   = tia_hlfsr_walk(TIA_HCNT_SHS);
    localparam tia_hstate_t TIA_HDEC_RHS   = tia_hlfsr_walk(TIA_HCNT_RHS);
    localparam tia_hstate_t TIA_HDEC_RCB   = tia_hlfsr_walk(TIA_HCNT_RCB);
    localparam tia_hstate_t TIA_HDEC_RHB   = tia_hlfsr_walk(TIA_HCNT_RHB);
    localparam tia_hstate_t TIA_HDEC_LRHB  = tia_hlfsr_walk(TIA_HCNT_LRHB);
    localparam tia_hstate_t TIA_HDEC_CNT   = tia_hlfsr_walk(TIA_HCNT_CNT);
    localparam tia_hstate_t TIA_HDEC_SHB   = tia_hlfsr_walk(TIA_HCNT_SHB);
    localparam tia_hstate_t TIA_OBJ_END    = tia_hlfsr_walk(TIA_OBJ_LAST);

endpackage

// File: rtl/tia_poly_prescaler.sv
// Divide-by-CLK_DIV advance strobe with count enable and synchronous clear.
module tia_poly_prescaler
    import tia_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rsynl,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick_c = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rsynl) begin
        if (!rsynl) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tia_poly_counter.sv
// XNOR-feedback polynomial counter with programmable end state and state decoders.
// Optional binary advance index enabled by defining TIA_POLY_COUNT_INDEX_EN.
module tia_poly_counter
    import tia_pkg::*;
#(
    parameter int unsigned             WIDTH      = 6,
    parameter logic [WIDTH-1:0]        TAPS       = WIDTH'(6'b110000),
    parameter logic [WIDTH-1:0]        END_STATE  = '0,
    parameter int unsigned             NUM_DEC    = 4,
    parameter logic [NUM_DEC*WIDTH-1:0] DEC_STATES = '0,
    parameter int unsigned             CLK_DIV    = 4
) (
    input  logic               clk,
    input  logic               rsynl,
    input  logic               rsyn,
    input  logic               en,
    output logic [WIDTH-1:0]   state,
    output logic               adv,
    output logic               wrap,
    output logic [NUM_DEC-1:0] dec,
    output logic               rsynd
`ifdef TIA_POLY_COUNT_INDEX_EN
    ,
    output logic [WIDTH-1:0]   index
`endif
);

    logic               tick_c;
    logic               pend;
    logic               pend_nxt_c;
    logic [WIDTH-1:0]   state_nxt_c;
    logic [WIDTH-1:0]   shift_c;
    logic               adv_nxt_c;
    logic               wrap_nxt_c;
    logic               rsynd_nxt_c;
    logic [NUM_DEC-1:0] dec_nxt_c;

    function automatic logic [NUM_DEC-1:0] decode(input logic [WIDTH-1:0] s);
        logic [NUM_DEC-1:0] d;
        for (int unsigned i = 0; i < NUM_DEC; i++) begin
            d[i] = (s == DEC_STATES[i*WIDTH +: WIDTH]);
        end
        return d;
    endfunction

    tia_poly_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rsynl  (rsynl),
        .en     (en),
        .clr    (rsyn),
        .tick_c (tick_c)
    );

    assign shift_c = {state[WIDTH-2:0], ~^(state & TAPS)};

    // Restart beats a tick; the all-ones lockup state is treated like the end state.
    always_comb begin
        state_nxt_c = state;
        adv_nxt_c   = 1'b0;
        wrap_nxt_c  = 1'b0;
        rsynd_nxt_c = 1'b0;
        pend_nxt_c  = pend;
        dec_nxt_c   = dec;
        if (rsyn) begin
            state_nxt_c = '0;
            pend_nxt_c  = 1'b1;
            dec_nxt_c   = decode('0);
        end else if (tick_c) begin
            adv_nxt_c   = 1'b1;
            rsynd_nxt_c = pend;
            pend_nxt_c  = 1'b0;
            if ((state == END_STATE) || (state == '1)) begin
                state_nxt_c = '0;
                wrap_nxt_c  = 1'b1;
            end else begin
                state_nxt_c = shift_c;
            end
            dec_nxt_c = decode(state_nxt_c);
        end
    end

    always_ff @(posedge clk or negedge rsynl) begin
        if (!rsynl) begin
            state <= '0;
            adv   <= 1'b0;
            wrap  <= 1'b0;
            rsynd <= 1'b0;
            pend  <= 1'b0;
            dec   <= decode('0);
        end else begin
            state <= state_nxt_c;
            adv   <= adv_nxt_c;
            wrap  <= wrap_nxt_c;
            rsynd <= rsynd_nxt_c;
            pend  <= pend_nxt_c;
            dec   <= dec_nxt_c;
        end
    end

`ifdef TIA_POLY_COUNT_INDEX_EN
    logic [WIDTH-1:0] index_nxt_c;

    // Advances since the last wrap, restart or reset, saturating.
    always_comb begin
        index_nxt_c = index;
        if (rsyn || (adv_nxt_c && wrap_nxt_c)) begin
            index_nxt_c = '0;
        end else if (adv_nxt_c && (index != '1)) begin
            index_nxt_c = index + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rsynl) begin
        if (!rsynl) begin
            index <= '0;
        end else begin
            index <= index_nxt_c;
        end
    end
`endif

endmodule

// File: tb/tb_tia_poly_counter.sv
// Self-checking bench: 57-state horizontal counter (CLK_DIV=4) and a 3-bit period-6 counter (CLK_DIV=1).
module tb_tia_poly_counter;
    import tia_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rsynl_a, rsyn_a, en_a;
    logic [5:0] state_a;
    logic       adv_a, wrap_a, rsynd_a;
    logic [3:0] dec_a;
    logic       rsynl_b, rsyn_b, en_b;
    logic [2:0] state_b;
    logic       adv_b, wrap_b, rsynd_b;
    logic [2:0] dec_b;
`ifdef TIA_POLY_COUNT_INDEX_EN
    logic [5:0] index_a;
    logic [2:0] index_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam int unsigned DEC_CNT_A [4] = '{TIA_HCNT_SHS, TIA_HCNT_RHS, TIA_HCNT_CNT, TIA_HCNT_SHB};

    tia_poly_counter #(
        .WIDTH      (6),
        .TAPS       (TIA_HLFSR_TAPS),
        .END_STATE  (TIA_HLFSR_END),
        .NUM_DEC    (4),
        .DEC_STATES ({TIA_HDEC_SHB, TIA_HDEC_CNT, TIA_HDEC_RHS, TIA_HDEC_SHS}),
        .CLK_DIV    (4)
    ) u_a (
        .clk   (clk),
        .rsynl (rsynl_a),
        .rsyn  (rsyn_a),
        .en    (en_a),
        .state (state_a),
        .adv   (adv_a),
        .wrap  (wrap_a),
        .dec   (dec_a),
        .rsynd (rsynd_a)
`ifdef TIA_POLY_COUNT_INDEX_EN
        ,
        .index (index_a)
`endif
    );

    tia_poly_counter #(
        .WIDTH      (3),
        .TAPS       (3'b110),
        .END_STATE  (3'b010),
        .NUM_DEC    (3),
        .DEC_STATES (9'b111_110_110),
        .CLK_DIV    (1)
    ) u_b (
        .clk   (clk),
        .rsynl (rsynl_b),
        .rsyn  (rsyn_b),
        .en    (en_b),
        .state (state_b),
        .adv   (adv_b),
        .wrap  (wrap_b),
        .dec   (dec_b),
        .rsynd (rsynd_b)
`ifdef TIA_POLY_COUNT_INDEX_EN
        ,
        .index (index_b)
`endif
    );

    task automatic test_reset();
        rsynl_a = 1'b0; rsyn_a = 1'b0; en_a = 1'b0;
        rsynl_b = 1'b0; rsyn_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (state_a !== 6'b0) begin n_bad++; $display("FAIL reset_state_a: got %b want 000000", state_a); end
        n_cmp++; if ({adv_a, wrap_a, rsynd_a} !== 3'b000) begin n_bad++; $display("FAIL reset_flags_a: got %b want 000", {adv_a, wrap_a, rsynd_a}); end
        n_cmp++; if (dec_a !== 4'b0) begin n_bad++; $display("FAIL reset_dec_a: got %b want 0000", dec_a); end
        n_cmp++; if (state_b !== 3'b0) begin n_bad++; $display("FAIL reset_state_b: got %b want 000", state_b); end
        n_cmp++; if (dec_b !== 3'b0) begin n_bad++; $display("FAIL reset_dec_b: got %b want 000", dec_b); end
`ifdef TIA_POLY_COUNT_INDEX_EN
        n_cmp++; if (index_a !== 6'd0) begin n_bad++; $display("FAIL reset_index_a: got %0d want 0", index_a); end
`endif
    endtask

    task automatic test_hseq();
        logic [5:0] exp_q[$];
        logic [5:0] e;
        int gap = 0;
        exp_q = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111110, 6'b111101};
        @(negedge clk);
        rsynl_a = 1'b1; en_a = 1'b1;
        for (int cyc = 0; cyc < 64 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            gap++;
            if (adv_a) begin
                e = exp_q.pop_front();
                n_cmp++; if (state_a !== e) begin n_bad++; $display("FAIL hseq_state: got %b want %b", state_a, e); end
                n_cmp++; if (gap != 4) begin n_bad++; $display("FAIL hseq_adv_gap: got %0d want 4", gap); end
                n_cmp++; if (wrap_a !== 1'b0) begin n_bad++; $display("FAIL hseq_wrap: got %b want 0", wrap_a); end
                gap = 0;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL hseq_timeout: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_hwrap();
        int nadv = 7;
        bit seen = 0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(negedge clk);
            if (adv_a) begin
                nadv++;
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if (dec_a[i] !== (nadv == int'(DEC_CNT_A[i]))) begin
                        n_bad++; $display("FAIL hwrap_dec%0d at adv %0d: got %b want %b", i, nadv, dec_a[i], nadv == int'(DEC_CNT_A[i]));
                    end
                end
                if (nadv == 56) begin
                    n_cmp++; if (state_a !== TIA_HLFSR_END) begin n_bad++; $display("FAIL hwrap_end_state: got %b want %b", state_a, TIA_HLFSR_END); end
                end
`ifdef TIA_POLY_COUNT_INDEX_EN
                n_cmp++;
                if (int'(index_a) != (wrap_a ? 0 : nadv)) begin
                    n_bad++; $display("FAIL hwrap_index at adv %0d: got %0d want %0d", nadv, index_a, wrap_a ? 0 : nadv);
                end
`endif
                if (wrap_a) begin
                    seen = 1;
                    n_cmp++; if (nadv != 57) begin n_bad++; $display("FAIL hwrap_period: got %0d want 57", nadv); end
                    n_cmp++; if (state_a !== 6'b0) begin n_bad++; $display("FAIL hwrap_state: got %b want 000000", state_a); end
                end
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL hwrap_timeout: got no wrap want wrap"); end
    endtask

    task automatic test_b_seq();
        logic [3:0] exp_q[$];
        logic [3:0] e;
        int dec_pulses = 0;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({1'b0, 3'b001}); exp_q.push_back({1'b0, 3'b011});
            exp_q.push_back({1'b0, 3'b110}); exp_q.push_back({1'b0, 3'b101});
            exp_q.push_back({1'b0, 3'b010}); exp_q.push_back({1'b1, 3'b000});
        end
        @(negedge clk);
        rsynl_b = 1'b1; en_b = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            n_cmp++; if (adv_b !== 1'b1) begin n_bad++; $display("FAIL bseq_adv: got %b want 1", adv_b); end
            e = exp_q.pop_front();
            n_cmp++; if (state_b !== e[2:0]) begin n_bad++; $display("FAIL bseq_state: got %b want %b", state_b, e[2:0]); end
            n_cmp++; if (wrap_b !== e[3]) begin n_bad++; $display("FAIL bseq_wrap at %b: got %b want %b", e[2:0], wrap_b, e[3]); end
            n_cmp++;
            if (dec_b !== {1'b0, e[2:0] == 3'b110, e[2:0] == 3'b110}) begin
                n_bad++; $display("FAIL bseq_dec at %b: got %b want %b", e[2:0], dec_b, {1'b0, e[2:0] == 3'b110, e[2:0] == 3'b110});
            end
            if (dec_b[0]) dec_pulses++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bseq_timeout: got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (dec_pulses != 2) begin n_bad++; $display("FAIL bseq_dec_pulses: got %0d want 2", dec_pulses); end
    endtask

    task automatic test_rsyn_wrap();
        bit found = 0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (state_b == 3'b010) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rsyn_find_010: got %b want 010", state_b); end
        rsyn_b = 1'b1;
        @(negedge clk);
        rsyn_b = 1'b0;
        n_cmp++; if ({state_b, wrap_b, adv_b, rsynd_b} !== 6'b000_000) begin n_bad++; $display("FAIL rsyn_edge: got %b want 000000", {state_b, wrap_b, adv_b, rsynd_b}); end
        @(negedge clk);
        n_cmp++; if ({state_b, adv_b, rsynd_b} !== 5'b001_11) begin n_bad++; $display("FAIL rsynd_first_adv: got %b want 00111", {state_b, adv_b, rsynd_b}); end
        @(negedge clk);
        n_cmp++; if ({state_b, rsynd_b} !== 4'b011_0) begin n_bad++; $display("FAIL rsynd_clear: got %b want 0110", {state_b, rsynd_b}); end
        rsyn_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rsyn_b = 1'b0;
        n_cmp++; if ({state_b, adv_b, rsynd_b} !== 5'b000_00) begin n_bad++; $display("FAIL rsyn_repeat_hold: got %b want 00000", {state_b, adv_b, rsynd_b}); end
        @(negedge clk);
        n_cmp++; if ({state_b, rsynd_b} !== 4'b001_1) begin n_bad++; $display("FAIL rsyn_repeat_pulse: got %b want 0011", {state_b, rsynd_b}); end
        @(negedge clk);
        n_cmp++; if (rsynd_b !== 1'b0) begin n_bad++; $display("FAIL rsyn_repeat_single: got %b want 0", rsynd_b); end
    endtask

    task automatic test_en_hold();
        bit found = 0;
        bit first = 1;
        rsyn_a = 1'b1;
        @(negedge clk);
        rsyn_a = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (adv_a) begin
                if (first) begin
                    n_cmp++; if (rsynd_a !== 1'b1) begin n_bad++; $display("FAIL en_rsynd_a: got %b want 1", rsynd_a); end
                    first = 0;
                end
                if (state_a == 6'b000011) found = 1;
            end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL en_find_011: got %b want 000011", state_a); end
        repeat (2) @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({state_a, adv_a, wrap_a, rsynd_a, dec_a} !== {6'b000011, 3'b000, 4'b0000}) begin
                n_bad++; $display("FAIL en_hold cyc %0d: got %b want %b", i, {state_a, adv_a, wrap_a, rsynd_a, dec_a}, {6'b000011, 3'b000, 4'b0000});
            end
        end
        en_a = 1'b1;
        @(negedge clk);
        n_cmp++; if (adv_a !== 1'b0) begin n_bad++; $display("FAIL en_resume_early: got %b want 0", adv_a); end
        @(negedge clk);
        n_cmp++; if ({adv_a, state_a} !== {1'b1, 6'b000111}) begin n_bad++; $display("FAIL en_resume_adv: got %b want 1000111", {adv_a, state_a}); end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        int gap = 0;
        bit seen_a = 0;
        repeat (2) @(negedge clk);
        #2 rsynl_a = 1'b0;
        #1;
        n_cmp++;
        if ({state_a, adv_a, wrap_a, rsynd_a, dec_a} !== 13'b0) begin
            n_bad++; $display("FAIL async_a: got %b want 0", {state_a, adv_a, wrap_a, rsynd_a, dec_a});
        end
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (state_b == 3'b101) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL async_find_101: got %b want 101", state_b); end
        #2 rsynl_b = 1'b0;
        #1;
        n_cmp++;
        if ({state_b, adv_b, wrap_b, rsynd_b, dec_b} !== 9'b0) begin
            n_bad++; $display("FAIL async_b: got %b want 0", {state_b, adv_b, wrap_b, rsynd_b, dec_b});
        end
        @(negedge clk);
        rsynl_a = 1'b1; rsynl_b = 1'b1;
        @(negedge clk);
        n_cmp++; if ({adv_b, state_b} !== 4'b1_001) begin n_bad++; $display("FAIL async_b_restart: got %b want 1001", {adv_b, state_b}); end
        gap = 1;
        if (adv_a) seen_a = 1;
        for (int cyc = 0; cyc < 10 && !seen_a; cyc++) begin
            @(negedge clk);
            gap++;
            if (adv_a) seen_a = 1;
        end
        n_cmp++; if (gap != 4) begin n_bad++; $display("FAIL async_a_gap: got %0d want 4", gap); end
        n_cmp++; if (state_a !== 6'b000001) begin n_bad++; $display("FAIL async_a_restart: got %b want 000001", state_a); end
    endtask

    initial begin
        test_reset();
        test_hseq();
        test_hwrap();
        test_b_seq();
        test_rsyn_wrap();
        test_en_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
